// File: rtl/mcpu_alu_pkg.sv
// Shared definitions for the MCPU sequential ALU: command encodings,
// FSM state type and flag-register bit positions.
package mcpu_alu_pkg;

   localparam logic [2:0] CMD_AND = 3'd0;
   localparam logic [2:0] CMD_OR  = 3'd1;
   localparam logic [2:0] CMD_XOR = 3'd2;
   localparam logic [2:0] CMD_ADD = 3'd3;
   localparam logic [2:0] CMD_SUB = 3'd4;
   localparam logic [2:0] CMD_ADC = 3'd5;
   localparam logic [2:0] CMD_SHR = 3'd6;
   localparam logic [2:0] CMD_MUL = 3'd7;

   localparam int unsigned FLAG_OF = 0;
   localparam int unsigned FLAG_SF = 1;
   localparam int unsigned FLAG_ZF = 2;
   localparam int unsigned FLAG_CF = 3;

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   function automatic logic [3:0] pack_flags(input logic cf, input logic zf,
                                             input logic sf, input logic of);
      logic [3:0] f;
      f          = '0;
      f[FLAG_CF] = cf;
      f[FLAG_ZF] = zf;
      f[FLAG_SF] = sf;
      f[FLAG_OF] = of;
      return f;
   endfunction

endpackage

// File: rtl/mcpu_alu_seq_if.sv
// Command/result bundle between the sequencer (master) and the ALU (slave).
interface mcpu_alu_seq_if #(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned CMD_SIZE  = 3
);
   logic [CMD_SIZE-1:0]  cmd;
   logic [WORD_SIZE-1:0] in1;
   logic [WORD_SIZE-1:0] in2;
   logic                 in_valid;
   logic                 in_ready;
   logic [WORD_SIZE-1:0] out;
   logic [WORD_SIZE-1:0] hi;
   logic                 out_valid;
   logic                 CF;
   logic                 ZF;
   logic                 SF;
   logic                 OF;

   modport master (
      output cmd, in1, in2, in_valid,
      input  in_ready, out, hi, out_valid, CF, ZF, SF, OF
   );

   modport slave (
      input  cmd, in1, in2, in_valid,
      output in_ready, out, hi, out_valid, CF, ZF, SF, OF
   );
endinterface

// File: rtl/mcpu_alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
module mcpu_alu_mul_seq #(
   parameter int unsigned WORD_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [WORD_SIZE-1:0]   a,
   input  logic [WORD_SIZE-1:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [2*WORD_SIZE-1:0] product
);
   localparam int unsigned CNT_W = $clog2(WORD_SIZE + 1);

   logic [WORD_SIZE-1:0]   mcand;
   logic [2*WORD_SIZE-1:0] acc;
   logic [CNT_W-1:0]       cnt;
   logic [WORD_SIZE:0]     sum;
   logic [2*WORD_SIZE-1:0] acc_next;

   // Multiplier lives in the low half of acc and is consumed as the partial
   // product shifts in from the top; product/done describe the value that the
   // current edge will produce, so the caller can register it on that edge.
   always_comb begin
      sum      = {1'b0, acc[2*WORD_SIZE-1:WORD_SIZE]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_next = {sum, acc[WORD_SIZE-1:1]};
   end

   assign busy    = (cnt != '0);
   assign done    = (cnt == CNT_W'(1));
   assign product = acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (start) begin
         mcand <= a;
         acc   <= {{WORD_SIZE{1'b0}}, b};
         cnt   <= CNT_W'(WORD_SIZE);
      end else if (busy) begin
         acc <= acc_next;
         cnt <= cnt - CNT_W'(1);
      end
   end
endmodule

// File: rtl/mcpu_alu_seq.sv
// Registered MCPU ALU: single-cycle logic/arithmetic ops, iterative MUL,
// persistent CF/ZF/SF/OF flag register and a valid/ready command input.
module mcpu_alu_seq
   import mcpu_alu_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 8,
   parameter int unsigned CMD_SIZE  = 3
) (
   input logic             clk,
   input logic             rst_n,
   mcpu_alu_seq_if.slave   bus
);
   localparam int unsigned MSB = WORD_SIZE - 1;

   state_t                 state;
   logic [WORD_SIZE-1:0]   out_r;
   logic [WORD_SIZE-1:0]   hi_r;
   logic [3:0]             flags;
   logic                   out_valid_r;
   logic                   in_ready_r;

   logic [WORD_SIZE-1:0]   res;
   logic                   cf_n;
   logic                   of_n;
   logic                   mul_start;
   logic                   mul_busy;
   logic                   mul_done;
   logic [2*WORD_SIZE-1:0] mul_prod;

   always_comb begin
      res  = '0;
      cf_n = flags[FLAG_CF];
      of_n = 1'b0;
      case (bus.cmd)
         CMD_AND: res = bus.in1 & bus.in2;
         CMD_OR:  res = bus.in1 | bus.in2;
         CMD_XOR: res = bus.in1 ^ bus.in2;
         CMD_ADD: begin
            {cf_n, res} = {1'b0, bus.in1} + {1'b0, bus.in2};
            of_n = (bus.in1[MSB] == bus.in2[MSB]) && (res[MSB] != bus.in1[MSB]);
         end
         CMD_ADC: begin
            {cf_n, res} = {1'b0, bus.in1} + {1'b0, bus.in2}
                        + {{WORD_SIZE{1'b0}}, flags[FLAG_CF]};
            of_n = (bus.in1[MSB] == bus.in2[MSB]) && (res[MSB] != bus.in1[MSB]);
         end
         CMD_SUB: begin
            {cf_n, res} = {1'b0, bus.in1} - {1'b0, bus.in2};
            of_n = (bus.in1[MSB] != bus.in2[MSB]) && (res[MSB] != bus.in1[MSB]);
         end
         CMD_SHR: begin
            res  = {1'b0, bus.in1[WORD_SIZE-1:1]};
            cf_n = bus.in1[0];
         end
         default: ;
      endcase
   end

   assign mul_start = (state == IDLE) && bus.in_valid && (bus.cmd == CMD_SIZE'(CMD_MUL));

   mcpu_alu_mul_seq #(.WORD_SIZE(WORD_SIZE)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (bus.in1),
      .b       (bus.in2),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         out_r       <= '0;
         hi_r        <= '0;
         flags       <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         out_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (mul_start) begin
                  state      <= MUL;
                  in_ready_r <= 1'b0;
               end else if (bus.in_valid) begin
                  out_r       <= res;
                  flags       <= pack_flags(cf_n, res == '0, res[MSB], of_n);
                  out_valid_r <= 1'b1;
               end
            end
            MUL: begin
               if (mul_done) begin
                  out_r       <= mul_prod[WORD_SIZE-1:0];
                  hi_r        <= mul_prod[2*WORD_SIZE-1:WORD_SIZE];
                  flags       <= pack_flags(|mul_prod[2*WORD_SIZE-1:WORD_SIZE],
                                            mul_prod[WORD_SIZE-1:0] == '0,
                                            mul_prod[MSB],
                                            |mul_prod[2*WORD_SIZE-1:WORD_SIZE]);
                  out_valid_r <= 1'b1;
                  state       <= IDLE;
                  in_ready_r  <= 1'b1;
               end else if (!mul_busy) begin
                  // Multiplier idle without a done pulse: recover without a result.
                  state      <= IDLE;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               in_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.out       = out_r;
   assign bus.hi        = hi_r;
   assign bus.out_valid = out_valid_r;
   assign bus.in_ready  = in_ready_r;
   assign bus.CF        = flags[FLAG_CF];
   assign bus.ZF        = flags[FLAG_ZF];
   assign bus.SF        = flags[FLAG_SF];
   assign bus.OF        = flags[FLAG_OF];
endmodule

// File: doc/mcpu_alu_seq.md
# mcpu_alu_seq

Parametrised, registered ALU for the MCPU datapath; next generation of the 8-bit combinational ALU. Adds width parameter, SUB/ADC/SHR, an iterative multi-cycle multiply, a persistent flag register (CF/ZF/SF/OF) and a valid/ready input handshake. Sits between the register-file read port and the write-back mux; the sequencer issues one command per accepted handshake.

## Interface
- WORD_SIZE, 8: operand/result width, ≥ 4.
- CMD_SIZE, 3: command width; fixed at 3 for the encodings below.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cmd  in  CMD_SIZE  operation, sampled on accept.
- in1, in2  in  WORD_SIZE  operands, sampled on accept.
- in_valid  in  1  command present.
- in_ready  out  1  ALU can accept; accept = in_valid & in_ready at rising clk.
- out  out  WORD_SIZE  result register (low word for MUL).
- hi  out  WORD_SIZE  high word of last MUL; unchanged by other ops.
- out_valid  out  1  one-cycle pulse: out/hi/flags were updated by this edge.
- CF, ZF, SF, OF  out  1 each  flag register.

## Operation
- Encodings: AND=0, OR=1, XOR=2, ADD=3 (compatible with the 2-bit ALU), SUB=4, ADC=5, SHR=6, MUL=7.
- AND/OR/XOR: out = bitwise result; CF preserved; OF cleared.
- ADD: {CF,out} = in1+in2. ADC: {CF,out} = in1+in2+CF (current register value). OF = operand signs equal and result sign differs.
- SUB: out = in1-in2 mod 2^WORD_SIZE; CF = borrow (in1 < in2 unsigned); OF = operand signs differ and result sign ≠ in1 sign.
- SHR: logical shift right by 1 of in1, in2 ignored; CF = in1[0]; OF cleared.
- MUL: unsigned shift-add, one partial-product bit per cycle; {hi,out} = in1*in2; CF = OF = (hi != 0).
- All ops: ZF = (out == 0), SF = out[WORD_SIZE-1].
- FSM states: IDLE, MUL. IDLE: in_ready=1; accepting a non-MUL op writes result+flags at that edge; accepting MUL loads multiplier, counter=WORD_SIZE, -> MUL. MUL: in_ready=0; each edge one iteration, counter decrements; on the edge where counter reaches 0, write out/hi/flags, pulse out_valid, -> IDLE.
- in_valid ignored while in_ready=0; sequencer holds cmd/operands until accepted.
- No output backpressure; consumer must capture on out_valid.

## Timing
- Reset (async assert, sync release): state IDLE, out=0, hi=0, CF=ZF=SF=OF=0, out_valid=0, in_ready=1 after release.
- Single-cycle ops: accepted at edge t -> out/flags/out_valid visible after edge t. Back-to-back accept every cycle; ADC at t+1 uses CF written at t.
- MUL: accepted at edge t -> in_ready low after t; result and out_valid after edge t+WORD_SIZE; in_ready high again after t+WORD_SIZE; next accept earliest at t+WORD_SIZE+1 edge.
- out and flags hold their values between out_valid pulses; during MUL they hold the previous result.
- rst_n asserted mid-MUL: abort immediately, all outputs to reset values, no out_valid.
- Width: all arithmetic in WORD_SIZE+1 bits for carry; MUL accumulator 2*WORD_SIZE bits.

## Structure
- Package mcpu_alu_pkg: cmd encoding constants (CMD_AND..CMD_MUL), FSM state type, flag-bit index constants.
- Sub-module mcpu_alu_mul_seq: iterative shift-add multiplier (start, operands, busy, done, 2*WORD_SIZE product), parametrised by WORD_SIZE; top holds FSM, single-cycle ops and flag register.

## Test plan (WORD_SIZE=8)
- ADD 0xFF+0x01 -> out=0x00, CF=1, ZF=1, SF=0, OF=0, out_valid one cycle after accept; then ADC 0x00+0x00 next cycle -> out=0x01, CF=0.
- SUB 0x10-0x20 -> out=0xF0, CF=1, SF=1, OF=0; SUB 0x80-0x01 -> out=0x7F, CF=0, OF=1.
- AND 0xF0&0x0F after a CF=1 op -> out=0x00, ZF=1, CF stays 1, OF=0; SHR 0x03 -> out=0x01, CF=1.
- MUL 0x10*0x10 -> in_ready low exactly 8 cycles, out=0x00, hi=0x01, CF=OF=1, ZF=1; in_valid pulsed during busy is ignored.
- Reset at cycle 4 of MUL 0xFF*0xFF -> outputs all 0, in_ready=1, no out_valid; subsequent ADD 0x01+0x02 -> out=0x03.
- Random back-to-back stream of 1000 mixed commands vs reference model: out, hi, flags match at every out_valid.
